// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath: opcode-driven sequencing of
// datapath enables/selects, with a ready handshake and watchdog on memory accesses.
module mips_mc_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ULAOp,
  output logic [1:0] PCSource,
  output logic       halted,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REX     = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEX     = 4'd11,
    S_IWB     = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  // Counter value at which one more idle cycle completes TIMEOUT wait cycles.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_error_q, bus_error_d;
  logic             wait_state;
  logic             timeout_hit;

  // The zero flag only qualifies PCWriteCond inside the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    wait_cnt_d  = '0;
    wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout_hit = (TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt_q == WAIT_LAST);

    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = S_REX;
          6'h23, 6'h2B: state_d = S_MEMADDR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08:        state_d = S_IEX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADDR: state_d = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_REX:     state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_IEX:     state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase

    // A ready on the final permitted cycle takes the normal path above.
    if (timeout_hit) begin
      state_d     = S_HALT;
      bus_error_d = 1'b1;
    end

    // Counter only survives while parked in a wait state; any transition clears it.
    if (wait_state && !mem_ready && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Moore decode straight off the state register, so reset clears every enable at once.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ULAOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ULAOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ULAOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB:   RegWrite = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_error = bus_error_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed scenarios plus random
// instruction streams checked against a per-instruction phase model.
module tb_mips_mc_control;

  localparam int unsigned TIMEOUT = 16;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADDR = 3, ST_MEMRD = 4,
                 ST_MEMWB = 5, ST_MEMWR = 6, ST_REX = 7, ST_RWB = 8, ST_BRANCH = 9,
                 ST_JUMP = 10, ST_IEX = 11, ST_IWB = 12, ST_HALT = 15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ULAOp, PCSource;
  logic       halted, bus_error;
  logic [3:0] state;
  ctrl_t      obs_ctrl;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  bit          exp_berr = 1'b0;

  always #5 clk = ~clk;

  mips_mc_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ULAOp(ULAOp),
    .PCSource(PCSource), .halted(halted), .bus_error(bus_error), .state(state)
  );

  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ULAOp, PCSource, halted};

  // Control table: only the nonzero outputs of each state are listed.
  function automatic ctrl_t expect_ctrl(input int st, input logic mr);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      ST_DECODE:  c.alu_src_b = 2'b11;
      ST_MEMADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEMRD:   begin c.mem_read = 1; c.iord = 1; end
      ST_MEMWB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
      ST_MEMWR:   begin c.mem_write = 1; c.iord = 1; end
      ST_REX:     begin c.alu_src_a = 1; c.ula_op = 2'b10; end
      ST_RWB:     begin c.reg_write = 1; c.reg_dst = 1; end
      ST_BRANCH:  begin c.alu_src_a = 1; c.ula_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      ST_JUMP:    begin c.pc_write = 1; c.pc_source = 2'b10; end
      ST_IEX:     begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_IWB:     c.reg_write = 1;
      ST_HALT:    c.halted = 1;
      default:    ;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, compare at the falling edge.
  task automatic cycle(input int st, input logic mr, input logic z, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"}, 32'(obs_ctrl), 32'(expect_ctrl(st, mr)));
    check({tag, ".bus_error"}, 32'(bus_error), 32'(exp_berr));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // w idle cycles before ready; at TIMEOUT idle cycles the access is abandoned.
  task automatic wait_phase(input int st, input int unsigned w, input string tag, output bit timed_out);
    int unsigned idle;
    idle = (w < TIMEOUT) ? w : TIMEOUT;
    for (int unsigned i = 0; i < idle; i++) cycle(st, 1'b0, 1'($urandom), tag);
    timed_out = (w >= TIMEOUT);
    if (timed_out) exp_berr = 1'b1;
    else cycle(st, 1'b1, 1'($urandom), tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input int unsigned w_fetch, input int unsigned w_mem,
                           input logic zb, output int unsigned ncyc, output bit halt_o);
    int unsigned start;
    bit to;
    start  = cyc;
    opcode = op;
    halt_o = 1'b0;
    wait_phase(ST_FETCH, w_fetch, "fetch", to);
    if (to) begin
      halt_o = 1'b1;
    end else begin
      cycle(ST_DECODE, 1'($urandom), 1'($urandom), "decode");
      case (op)
        6'h00: begin cycle(ST_REX, 1'($urandom), 1'($urandom), "rex"); cycle(ST_RWB, 1'($urandom), 1'($urandom), "rwb"); end
        6'h23: begin
          cycle(ST_MEMADDR, 1'($urandom), 1'($urandom), "memaddr");
          wait_phase(ST_MEMRD, w_mem, "memrd", to);
          if (to) halt_o = 1'b1;
          else cycle(ST_MEMWB, 1'($urandom), 1'($urandom), "memwb");
        end
        6'h2B: begin
          cycle(ST_MEMADDR, 1'($urandom), 1'($urandom), "memaddr");
          wait_phase(ST_MEMWR, w_mem, "memwr", to);
          if (to) halt_o = 1'b1;
        end
        6'h04: cycle(ST_BRANCH, 1'($urandom), zb, "branch");
        6'h02: cycle(ST_JUMP, 1'($urandom), 1'($urandom), "jump");
        6'h08: begin cycle(ST_IEX, 1'($urandom), 1'($urandom), "iex"); cycle(ST_IWB, 1'($urandom), 1'($urandom), "iwb"); end
        default: halt_o = 1'b1;
      endcase
    end
    ncyc = cyc - start;
  endtask

  task automatic halt_phase(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(ST_HALT, 1'($urandom), 1'($urandom), "halt");
  endtask

  // Reset arrives mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_berr = 1'b0;
    check("rst.async.state", 32'(state), 32'(ST_RST));
    check("rst.async.ctrl", 32'(obs_ctrl), 32'(0));
    check("rst.async.bus_error", 32'(bus_error), 32'(0));
    @(posedge clk);
    #1;
    check("rst.held.state", 32'(state), 32'(ST_RST));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.release.state", 32'(state), 32'(ST_RST));
    check("rst.release.ctrl", 32'(obs_ctrl), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n;
    bit          h;
    logic [5:0]  op;
    logic [5:0]  legal_ops [6];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00;
    do_reset();

    run_instr(6'h00, 0, 0, 1'b0, n, h);
    check("cpi.rtype", 32'(n), 32'(4));
    run_instr(6'h23, 0, 3, 1'b0, n, h);
    check("cpi.lw_wait3", 32'(n), 32'(8));
    run_instr(6'h23, 0, 0, 1'b0, n, h);
    check("cpi.lw", 32'(n), 32'(5));
    run_instr(6'h2B, 0, 0, 1'b0, n, h);
    check("cpi.sw", 32'(n), 32'(4));
    run_instr(6'h04, 0, 0, 1'b0, n, h);
    check("cpi.beq_z0", 32'(n), 32'(3));
    run_instr(6'h04, 0, 0, 1'b1, n, h);
    check("cpi.beq_z1", 32'(n), 32'(3));
    run_instr(6'h02, 0, 0, 1'b0, n, h);
    check("cpi.j", 32'(n), 32'(3));
    run_instr(6'h08, 0, 0, 1'b0, n, h);
    check("cpi.addi", 32'(n), 32'(4));

    run_instr(6'h3F, 0, 0, 1'b0, n, h);
    check("illegal.halts", 32'(h), 32'(1));
    halt_phase(20);
    do_reset();

    run_instr(6'h00, 15, 0, 1'b0, n, h);
    check("fetch.ready_on_last", 32'(n), 32'(19));
    run_instr(6'h00, 16, 0, 1'b0, n, h);
    check("fetch.timeout_cycles", 32'(n), 32'(16));
    halt_phase(3);
    do_reset();
    run_instr(6'h23, 0, 20, 1'b0, n, h);
    check("memrd.timeout", 32'(h), 32'(1));
    halt_phase(2);
    do_reset();
    run_instr(6'h2B, 0, 15, 1'b0, n, h);
    check("memwr.ready_on_last", 32'(n), 32'(19));

    opcode = 6'h2B;
    cycle(ST_FETCH, 1'b1, 1'b0, "sw_rst.fetch");
    cycle(ST_DECODE, 1'b0, 1'b0, "sw_rst.decode");
    cycle(ST_MEMADDR, 1'b0, 1'b0, "sw_rst.memaddr");
    cycle(ST_MEMWR, 1'b0, 1'b0, "sw_rst.memwr");
    check("sw_rst.memwrite_before", 32'(MemWrite), 32'(1));
    do_reset();

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) < 14) begin
        op = legal_ops[$urandom_range(0, 5)];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op,
                ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3),
                1'($urandom), n, h);
      if (h) begin
        halt_phase($urandom_range(1, 4));
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It decodes the opcode and, cycle by cycle, drives every datapath enable and mux select, including the 2-bit ULAOp consumed by the ALU-control decoder.
- Memory accesses use a ready handshake with a watchdog.
- An illegal opcode or a memory timeout parks the core in HALT until reset.

Parameters:
- TIMEOUT, 16, max cycles spent waiting for mem_ready in one access before bus error; 0 disables the watchdog.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = reg A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- ULAOp  out  2  00 = add, 01 = sub, 10 = R-type (decode funct).
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- halted  out  1  core is in HALT.
- bus_error  out  1  sticky; memory watchdog expired.
- state  out  4  current state encoding, for debug.

Behaviour:
- State register and wait counter use an asynchronous reset.
- Reset state: RST. Every output is 0 in reset, including bus_error and halted. All outputs are Moore outputs of state, except PCWrite/IRWrite in FETCH, which are gated by mem_ready.
- Default for every output in every state is 0; each state lists only its nonzero outputs.
- Encodings: RST=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BRANCH=9, JUMP=10, IEX=11, IWB=12, HALT=15.
- RST: -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ULAOp=00, PCSource=00.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle, then -> DECODE.
  - Otherwise stay in FETCH; PCWrite and IRWrite stay 0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ULAOp=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> REX
  - 0x23 or 0x2B -> MEMADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> IEX
  - any other -> HALT
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ULAOp=00. Opcode 0x23 -> MEMRD, else -> MEMWR.
- MEMRD: MemRead=1, IorD=1. mem_ready -> MEMWB, else stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEMWR: MemWrite=1, IorD=1. mem_ready -> FETCH, else stay.
- REX: ALUSrcA=1, ALUSrcB=00, ULAOp=10. -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ULAOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10, ULAOp=00. -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- HALT: halted=1, every other control output 0. Absorbing; only reset exits.
- Watchdog (FETCH, MEMRD, MEMWR):
  - Counter clears on entry to each of these states and counts each cycle with mem_ready=0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT while mem_ready=0 -> HALT, and bus_error sets and holds.
  - mem_ready=1 on the same cycle the counter reaches TIMEOUT wins: normal transition, no error.
- Cycles per instruction with mem_ready tied high: R=4, lw=5, sw=4, beq=3, j=3, addi=4.
- Reset asserted mid-instruction: returns to RST immediately; no write enable may stay high.

Test Plan:
- Reset, then mem_ready=1 and opcode=0x00: state trace RST, FETCH, DECODE, REX, RWB, FETCH; ULAOp=10 in REX; RegWrite=1 and RegDst=1 in RWB only.
- lw (0x23) with mem_ready held low 3 cycles in MEMRD: MemRead=1 and IorD=1 for 4 cycles, then MEMWB with RegWrite=1 and MemtoReg=1; total 8 cycles FETCH to FETCH.
- beq (0x04): BRANCH asserts PCWriteCond=1, ULAOp=01, PCSource=01; PCWrite stays 0 in BRANCH for zero=0 and zero=1.
- Illegal opcode 0x3F: DECODE -> HALT; halted=1 held for 20 cycles with all enables 0; deassert and release reset -> RST -> FETCH.
- TIMEOUT=16, mem_ready=0 in FETCH: HALT entered after 16 wait cycles with bus_error=1 and PCWrite never asserted. Repeat with mem_ready=1 on the 16th wait cycle: -> DECODE, bus_error=0.
- Reset asserted in MEMWR with MemWrite=1: MemWrite drops asynchronously; state=0.
